// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory read-port arbiter.
package imem_pkg;
    localparam int AW = 6;
    localparam int DW = 32;

    typedef enum logic {
        CORE_PRI = 1'b0,
        DBG_PRI  = 1'b1
    } arb_state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;
endpackage

// File: rtl/imem_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and imem.
interface imem_arbiter_if #(
    parameter int AW = imem_pkg::AW,
    parameter int DW = imem_pkg::DW
);
    logic          c_valid;
    logic [AW-1:0] c_addr;
    logic          c_ready;
    logic          c_rvalid;
    logic [DW-1:0] c_rdata;
    logic          d_valid;
    logic [AW-1:0] d_addr;
    logic          d_ready;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] imem_a;
    logic [DW-1:0] imem_y;

    // Arbiter side
    modport slave (
        input  c_valid, c_addr, d_valid, d_addr, imem_y,
        output c_ready, c_rvalid, c_rdata, d_ready, d_rvalid, d_rdata, imem_a
    );

    // Requester / memory side
    modport master (
        output c_valid, c_addr, d_valid, d_addr, imem_y,
        input  c_ready, c_rvalid, c_rdata, d_ready, d_rvalid, d_rdata, imem_a
    );
endinterface

// File: rtl/imem_arbiter.sv
// Burst-weighted round-robin arbiter sharing imem's combinational read port
// between core fetch (port 0) and debug/loader (port 1). One lookup per
// cycle, registered one-cycle response to the winner.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int AW         = imem_pkg::AW,
    parameter int DW         = imem_pkg::DW,
    parameter int CORE_BURST = 4,
    localparam int CW        = $clog2(CORE_BURST + 1)
) (
    input  logic        clk,
    input  logic        reset,
    imem_arbiter_if.slave bus
);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          gnt_vld;
    logic          gnt_port;
    logic          c_gnt, d_gnt;
    logic          c_rvalid_q, d_rvalid_q;
    logic [DW-1:0] c_rdata_q, d_rdata_q;

    // FSM state and burst counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CORE_PRI;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant selection, next-state and imem address mux
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_vld  = 1'b0;
        gnt_port = PORT_CORE;
        // counter saturates; in practice it is cleared on reaching CORE_BURST
        cnt_inc  = (cnt_q == CW'(CORE_BURST)) ? cnt_q : cnt_q + CW'(1);
        case (state_q)
            CORE_PRI: begin
                if (bus.c_valid) begin
                    gnt_vld  = 1'b1;
                    gnt_port = PORT_CORE;
                    if (bus.d_valid) begin
                        // debug is being held off: count the burst
                        if (cnt_inc == CW'(CORE_BURST)) begin
                            state_d = DBG_PRI;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end else if (bus.d_valid) begin
                    gnt_vld  = 1'b1;
                    gnt_port = PORT_DBG;
                    cnt_d    = '0;
                end
            end
            DBG_PRI: begin
                if (bus.d_valid) begin
                    gnt_vld  = 1'b1;
                    gnt_port = PORT_DBG;
                    state_d  = CORE_PRI;
                    cnt_d    = '0;
                end else if (bus.c_valid) begin
                    // debug withdrew; no contention, so history restarts at 0
                    gnt_vld  = 1'b1;
                    gnt_port = PORT_CORE;
                    state_d  = CORE_PRI;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = CORE_PRI;
                cnt_d   = '0;
            end
        endcase
        c_gnt = gnt_vld && (gnt_port == PORT_CORE);
        d_gnt = gnt_vld && (gnt_port == PORT_DBG);
        if (c_gnt)      bus.imem_a = bus.c_addr;
        else if (d_gnt) bus.imem_a = bus.d_addr;
        else            bus.imem_a = '0;
    end

    // Response registers: capture imem data for the winner, one-cycle rvalid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            c_rvalid_q <= c_gnt;
            d_rvalid_q <= d_gnt;
            if (c_gnt) c_rdata_q <= bus.imem_y;
            if (d_gnt) d_rdata_q <= bus.imem_y;
        end
    end

    assign bus.c_ready  = c_gnt;
    assign bus.d_ready  = d_gnt;
    assign bus.c_rvalid = c_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.c_rdata  = c_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: instance A uses CORE_BURST=4, instance B
// uses CORE_BURST=1; both see identical requester stimulus.
module tb_imem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    imem_arbiter_if #(.AW(6), .DW(32)) ia ();
    imem_arbiter_if #(.AW(6), .DW(32)) ib ();

    imem_arbiter #(.AW(6), .DW(32), .CORE_BURST(4)) ua (.clk(clk), .reset(rst_n), .bus(ia));
    imem_arbiter #(.AW(6), .DW(32), .CORE_BURST(1)) ub (.clk(clk), .reset(rst_n), .bus(ib));

    // imem models
    assign ia.imem_y = 32'hC0DE_0000 | {26'b0, ia.imem_a};
    assign ib.imem_y = 32'hC0DE_0000 | {26'b0, ib.imem_a};

    always #5 clk = ~clk;

    logic [31:0] ec_a, ed_a, ec_b, ed_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic [5:0] ca, input logic dv, input logic [5:0] da);
        ia.c_valid = cv; ia.c_addr = ca; ia.d_valid = dv; ia.d_addr = da;
        ib.c_valid = cv; ib.c_addr = ca; ib.d_valid = dv; ib.d_addr = da;
    endtask

    // One contention cycle: ga/gb = 1 when debug is expected to win on A/B
    task automatic cont(input string tag, input logic ga, input logic gb,
                        input logic [5:0] ca, input logic [5:0] da);
        @(negedge clk);
        drive(1'b1, ca, 1'b1, da);
        #1;
        chk({tag, "_a_crdy"}, 32'(ia.c_ready), 32'(!ga));
        chk({tag, "_a_drdy"}, 32'(ia.d_ready), 32'(ga));
        chk({tag, "_b_crdy"}, 32'(ib.c_ready), 32'(!gb));
        chk({tag, "_b_drdy"}, 32'(ib.d_ready), 32'(gb));
        chk({tag, "_a_imem"}, 32'(ia.imem_a), 32'(ga ? da : ca));
        if (ga) ed_a = 32'hC0DE_0000 | {26'b0, da}; else ec_a = 32'hC0DE_0000 | {26'b0, ca};
        if (gb) ed_b = 32'hC0DE_0000 | {26'b0, da}; else ec_b = 32'hC0DE_0000 | {26'b0, ca};
        @(posedge clk); #1;
        chk({tag, "_a_crv"}, 32'(ia.c_rvalid), 32'(!ga));
        chk({tag, "_a_drv"}, 32'(ia.d_rvalid), 32'(ga));
        chk({tag, "_b_crv"}, 32'(ib.c_rvalid), 32'(!gb));
        chk({tag, "_b_drv"}, 32'(ib.d_rvalid), 32'(gb));
        chk({tag, "_a_crd"}, ia.c_rdata, ec_a);
        chk({tag, "_a_drd"}, ia.d_rdata, ed_a);
        chk({tag, "_b_crd"}, ib.c_rdata, ec_b);
        chk({tag, "_b_drd"}, ib.d_rdata, ed_b);
    endtask

    initial begin
        logic [5:0] dbg_addrs [3];
        dbg_addrs[0] = 6'd63; dbg_addrs[1] = 6'd0; dbg_addrs[2] = 6'd1;

        // reset with valids low
        drive(1'b0, 6'd0, 1'b0, 6'd0);
        #1;
        chk("rst_crv", 32'(ia.c_rvalid), 32'd0);
        chk("rst_drv", 32'(ia.d_rvalid), 32'd0);
        chk("rst_crd", ia.c_rdata, 32'd0);
        chk("rst_drd", ia.d_rdata, 32'd0);
        chk("rst_imem", 32'(ia.imem_a), 32'd0);
        chk("rst_rdy", {30'd0, ia.c_ready, ia.d_ready}, 32'd0);
        // readies are combinational and follow valids even in reset
        @(negedge clk);
        drive(1'b1, 6'd5, 1'b0, 6'd0);
        #1;
        chk("rst_crdy_follow", 32'(ia.c_ready), 32'd1);
        @(posedge clk); #1;
        chk("rst_no_rv", 32'(ia.c_rvalid), 32'd0);
        @(negedge clk);
        drive(1'b0, 6'd0, 1'b0, 6'd0);
        rst_n = 1'b1;

        // idle after release
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("idle_rdy", {30'd0, ia.c_ready, ia.d_ready}, 32'd0);
            @(posedge clk); #1;
            chk("idle_rv", {30'd0, ia.c_rvalid, ia.d_rvalid}, 32'd0);
        end

        // core only, back-to-back
        for (int i = 0; i <= 26; i++) begin
            @(negedge clk);
            drive(1'b1, 6'(i), 1'b0, 6'd0);
            #1;
            chk("core_rdy", 32'(ia.c_ready), 32'd1);
            chk("core_imem", 32'(ia.imem_a), 32'(i));
            @(posedge clk); #1;
            chk("core_rv", 32'(ia.c_rvalid), 32'd1);
            chk("core_rd", ia.c_rdata, 32'hC0DE_0000 + 32'(i));
            chk("core_drv", 32'(ia.d_rvalid), 32'd0);
        end
        @(negedge clk);
        drive(1'b0, 6'd0, 1'b0, 6'd0);
        @(posedge clk); #1;
        chk("core_rv_drop", 32'(ia.c_rvalid), 32'd0);
        chk("core_rd_hold", ia.c_rdata, 32'hC0DE_001A);

        // debug only
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, 6'd0, 1'b1, dbg_addrs[i]);
            #1;
            chk("dbg_rdy", 32'(ia.d_ready), 32'd1);
            chk("dbg_crdy", 32'(ia.c_ready), 32'd0);
            @(posedge clk); #1;
            chk("dbg_rv", 32'(ia.d_rvalid), 32'd1);
            chk("dbg_rd", ia.d_rdata, 32'hC0DE_0000 | {26'b0, dbg_addrs[i]});
            chk("dbg_crv", 32'(ia.c_rvalid), 32'd0);
        end

        // fresh reset, then continuous contention
        @(negedge clk);
        drive(1'b0, 6'd0, 1'b0, 6'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ec_a = '0; ed_a = '0; ec_b = '0; ed_b = '0;
        for (int i = 0; i < 12; i++)
            cont("cont", (i % 5) == 4, (i % 2) == 1, 6'(i), 6'(32 + i));

        // A now has cnt=2 in CORE_PRI; reset between grant and edge
        @(negedge clk);
        drive(1'b1, 6'd7, 1'b1, 6'd40);
        #1;
        chk("mid_crdy", 32'(ia.c_ready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_crv", 32'(ia.c_rvalid), 32'd0);
        chk("mid_async_crd", ia.c_rdata, 32'd0);
        @(posedge clk); #1;
        chk("mid_a_rv", {30'd0, ia.c_rvalid, ia.d_rvalid}, 32'd0);
        chk("mid_b_rv", {30'd0, ib.c_rvalid, ib.d_rvalid}, 32'd0);
        chk("mid_a_crd", ia.c_rdata, 32'd0);
        rst_n = 1'b1;
        ec_a = '0; ed_a = '0; ec_b = '0; ed_b = '0;
        // burst history was lost: four core grants before debug again
        for (int i = 0; i < 5; i++)
            cont("post", i == 4, (i % 2) == 1, 6'(10 + i), 6'(50 + i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Round-robin, burst-weighted arbiter that shares the single combinational read port of `imem` (6-bit word address in, 32-bit instruction out) between two requesters: the core instruction fetch (port 0) and the debug/loader read port (port 1). The arbiter grants at most one lookup per cycle, drives `imem`'s address, and returns the instruction to the winner through a registered one-cycle response. Under contention the core may take up to `CORE_BURST` consecutive grants before a waiting debug request must be served.

## Interface
- `AW`, 6: `imem` word-address width.
- `DW`, 32: instruction width.
- `CORE_BURST`, 4: maximum consecutive core grants while debug waits; legal range 1..15.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `c_valid`  in  1  core fetch request.
- `c_addr`  in  AW  core fetch address.
- `c_ready`  out  1  core request granted this cycle; transfer on `c_valid & c_ready`.
- `c_rvalid`  out  1  core response valid (one-cycle pulse).
- `c_rdata`  out  DW  core response data.
- `d_valid`, `d_addr`, `d_ready`, `d_rvalid`, `d_rdata`: same as the `c_*` signals, for the debug port.
- `imem_a`  out  AW  address to `imem`.
- `imem_y`  in  DW  instruction from `imem`.

## Operation
- FSM states: `CORE_PRI` and `DBG_PRI`. The FSM also holds the burst counter `cnt` (width clog2(CORE_BURST+1), saturating).
- `CORE_PRI` behaviour:
  - `c_valid`: grant core. If `d_valid` is also set, increment `cnt`. If the new `cnt` equals `CORE_BURST`, go to `DBG_PRI` and clear `cnt`.
  - `c_valid` and not `d_valid`: grant core and clear `cnt`.
  - Only `d_valid`: grant debug, stay in `CORE_PRI`, clear `cnt`.
- `DBG_PRI` behaviour:
  - `d_valid`: grant debug, go to `CORE_PRI`, clear `cnt`.
  - Only `c_valid`: grant core, go to `CORE_PRI`. Set `cnt` to 1 if `d_valid`, otherwise 0. (In this branch `d_valid` is 0, so `cnt` becomes 0.)
- Neither valid: no grant and no state change.
- `c_ready`/`d_ready` are combinational from the current state and valids. At most one is high; ready never rises without the matching valid.
- `imem_a` is combinational: the granted port's address, or `'0` when nothing is granted.
- Response: on a grant, at the next rising edge `imem_y` is captured into the winner's `*_rdata` and its `*_rvalid` is set for exactly one cycle.
  - The losing port's `*_rdata` holds its previous value.
  - Responses have no back-pressure. A requester must accept every response.
- Requesters may hold or change valid and address at any time. An ungranted request has no side effect.

## Timing
- Request-to-response latency is exactly 1 cycle. Back-to-back grants to the same port give one response per cycle.
- Throughput is one `imem` read per cycle total.
- Worst-case debug wait under continuous core traffic is `CORE_BURST` cycles. Core wait is at most 1 cycle.
- Reset (asynchronous, immediate) sets:
  - state `CORE_PRI`, `cnt` 0;
  - `c_rvalid`/`d_rvalid` to 0, `c_rdata`/`d_rdata` to 0.
  - `imem_a` and the readies are 0 while the valids are 0.
  - The readies follow the valids even during reset, since they are combinational.
- Reset mid-operation: a response pending for the next edge is dropped (no `rvalid`), and burst history is lost.
- `CORE_BURST=1` under contention gives strict alternation C,D,C,D.

## Structure
- Shared package `imem_pkg`:
  - `AW`/`DW` defaults;
  - `arb_state_t` enum (`CORE_PRI`, `DBG_PRI`);
  - `PORT_CORE`/`PORT_DBG` constants.
- A single module with no sub-modules. `imem` is instantiated alongside it at the top level, not inside it.
- Target size is roughly 150 lines. There are three always blocks: one for the FSM and counter, one for the grant/mux logic, and one for the response registers.

## Test plan
- Bench `imem` model returns `32'hC0DE_0000 | a`.
- Reset with valids low: all `rvalid` 0, `rdata` 0, `imem_a` 0. Deassert reset, then idle 5 cycles: no readies and no responses.
- Core only, `c_addr` 0..26 on consecutive cycles: `c_ready`=1 every cycle. `c_rvalid` pulses the following cycle with `c_rdata`=`32'hC0DE_0000+addr`. `d_rvalid` stays 0.
- Both valid continuously, `CORE_BURST=4`: grant pattern C,C,C,C,D repeats. `d_rdata` equals `32'hC0DE_0000|d_addr` each time it is granted.
- `CORE_BURST=1`, both valid: strict alternation C,D,C,D starting with C after reset.
- Debug only, addresses 63,0,1: `d_ready`=1 each cycle, with responses `32'hC0DE_003F`, `32'hC0DE_0000`, `32'hC0DE_0001`.
- Reset pulled low between a grant and the next edge: no `rvalid` at that edge. After release, the FSM is in `CORE_PRI` with `cnt`=0, so the next contention yields 4 core grants before a debug grant.
